// File: rtl/range_input_framer.sv
// Assembles little-endian byte pairs from an 8-bit pin bus into 16-bit words
// and frames them with one-cycle go/finish strobes for the downstream consumer.
module range_input_framer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [7:0]       byte_in,
   input  logic             byte_valid,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] data_out,
   output logic             go,
   output logic             finish,
   output logic [CNT_W-1:0] word_count,
   output logic             busy,
   output logic             frame_error
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_END  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [1:0]       state_r;
   logic [1:0]       next_state_s;
   logic [7:0]       low_byte_r;
   logic [WIDTH-1:0] data_out_r;
   logic             go_r;
   logic             finish_r;
   logic [CNT_W-1:0] word_count_r;
   logic             busy_r;
   logic             frame_error_r;

   logic             word_done_s;
   logic             capture_lo_s;
   logic             set_error_s;
   logic             clear_frame_s;

   // Next-state and datapath-enable decode
   always_comb begin
      next_state_s  = state_r;
      word_done_s   = 1'b0;
      capture_lo_s  = 1'b0;
      set_error_s   = 1'b0;
      clear_frame_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               next_state_s  = ST_LO;
               clear_frame_s = 1'b1;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_LO: begin
            // An empty frame must not finish: there was never a go to pair it with
            if (stop) begin
               if (word_count_r != CNT_ZERO) begin
                  next_state_s = ST_END;
               end else begin
                  next_state_s = ST_IDLE;
                  set_error_s  = 1'b1;
               end
            end else if (byte_valid) begin
               capture_lo_s = 1'b1;
               next_state_s = ST_HI;
            end else begin
               next_state_s = ST_LO;
            end
         end
         ST_HI: begin
            if (byte_valid) begin
               word_done_s  = 1'b1;
               next_state_s = stop ? ST_END : ST_LO;
            end else if (stop) begin
               set_error_s  = 1'b1;
               next_state_s = ST_END;
            end else begin
               next_state_s = ST_HI;
            end
         end
         ST_END: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s = ST_IDLE;
         end
      endcase
   end

   // State, word assembly and registered strobes; finish trails END by one
   // cycle so it can never coincide with a go issued on entry to END
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         low_byte_r    <= 8'd0;
         data_out_r    <= {WIDTH{1'b0}};
         go_r          <= 1'b0;
         finish_r      <= 1'b0;
         word_count_r  <= CNT_ZERO;
         busy_r        <= 1'b0;
         frame_error_r <= 1'b0;
      end else begin
         state_r  <= next_state_s;
         busy_r   <= (next_state_s != ST_IDLE);
         go_r     <= word_done_s && (word_count_r == CNT_ZERO);
         finish_r <= (state_r == ST_END);
         if (capture_lo_s) begin
            low_byte_r <= byte_in;
         end else begin
            low_byte_r <= low_byte_r;
         end
         if (word_done_s) begin
            data_out_r <= {byte_in, low_byte_r};
         end else begin
            data_out_r <= data_out_r;
         end
         if (clear_frame_s) begin
            word_count_r <= CNT_ZERO;
         end else if (word_done_s && (word_count_r != CNT_MAX)) begin
            word_count_r <= word_count_r + CNT_ONE;
         end else begin
            word_count_r <= word_count_r;
         end
         if (clear_frame_s) begin
            frame_error_r <= 1'b0;
         end else if (set_error_s) begin
            frame_error_r <= 1'b1;
         end else begin
            frame_error_r <= frame_error_r;
         end
      end
   end

   assign data_out    = data_out_r;
   assign go          = go_r;
   assign finish      = finish_r;
   assign word_count  = word_count_r;
   assign busy        = busy_r;
   assign frame_error = frame_error_r;

endmodule

// File: tb/tb_range_input_framer.sv
// Directed, table-driven bench for range_input_framer with hand-written
// sequences for asynchronous reset and word-count saturation.
module tb_range_input_framer;

   logic        clock = 1'b0;
   logic        reset;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        start;
   logic        stop;
   logic [15:0] data_out;
   logic        go;
   logic        finish;
   logic [7:0]  word_count;
   logic        busy;
   logic        frame_error;

   int checks   = 0;
   int failures = 0;

   range_input_framer #(.WIDTH(16), .CNT_W(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .byte_in     (byte_in),
      .byte_valid  (byte_valid),
      .start       (start),
      .stop        (stop),
      .data_out    (data_out),
      .go          (go),
      .finish      (finish),
      .word_count  (word_count),
      .busy        (busy),
      .frame_error (frame_error)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        st;
      logic        sp;
      logic        bv;
      logic [7:0]  b;
      logic [15:0] e_data;
      logic        e_go;
      logic        e_fin;
      logic [7:0]  e_wc;
      logic        e_busy;
      logic        e_fe;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic sp, input logic bv, input logic [7:0] b,
                      input logic [15:0] d, input logic g, input logic f, input logic [7:0] wc,
                      input logic bz, input logic fe);
      vec_t v;
      v.st = st; v.sp = sp; v.bv = bv; v.b = b;
      v.e_data = d; v.e_go = g; v.e_fin = f; v.e_wc = wc; v.e_busy = bz; v.e_fe = fe;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the rising edge
   task automatic cycle(input logic st, input logic sp, input logic bv, input logic [7:0] b);
      start = st; stop = sp; byte_valid = bv; byte_in = b;
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] pack_out();
      return {4'd0, data_out, go, finish, word_count, busy, frame_error};
   endfunction

   initial begin
      int go_count;
      logic [7:0] lo_b;
      logic [7:0] hi_b;
      logic [15:0] last_word;

      reset = 1'b1; start = 1'b0; stop = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
      #1;
      check("reset_state", pack_out(), 32'd0);
      @(posedge clock); @(posedge clock); #1;
      reset = 1'b0;

      //   st    sp    bv    byte    data      go    fin   wc     busy  fe
      // two-word frame
      add(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'h34, 16'h0000, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'h12, 16'h1234, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'h78, 16'h1234, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'h56, 16'h5678, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 8'h00, 16'h5678, 1'b0, 1'b0, 8'd2, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 8'h00, 16'h5678, 1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 8'h00, 16'h5678, 1'b0, 1'b0, 8'd2, 1'b0, 1'b0);
      // odd byte count, stop while awaiting the high byte
      add(1'b1, 1'b0, 1'b0, 8'h00, 16'h5678, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'hAA, 16'h5678, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'hBB, 16'hBBAA, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'hCC, 16'hBBAA, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 8'h00, 16'hBBAA, 1'b0, 1'b0, 8'd1, 1'b1, 1'b1);
      add(1'b0, 1'b0, 1'b0, 8'h00, 16'hBBAA, 1'b0, 1'b1, 8'd1, 1'b0, 1'b1);
      // empty frame, then start+stop together clears the error and enters LO
      add(1'b1, 1'b0, 1'b0, 8'h00, 16'hBBAA, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b0, 8'h00, 16'hBBAA, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
      add(1'b0, 1'b0, 1'b0, 8'h00, 16'hBBAA, 1'b0, 1'b0, 8'd0, 1'b0, 1'b1);
      add(1'b1, 1'b1, 1'b0, 8'h00, 16'hBBAA, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      // high byte and stop together; start ignored in LO and END; bytes ignored in IDLE
      add(1'b1, 1'b0, 1'b1, 8'hFF, 16'hBBAA, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 8'h01, 16'h01FF, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
      add(1'b1, 1'b0, 1'b0, 8'h00, 16'h01FF, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'h99, 16'h01FF, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
      add(1'b0, 1'b1, 1'b0, 8'h00, 16'h01FF, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
      // stop in LO drops a concurrent byte
      add(1'b1, 1'b0, 1'b0, 8'h00, 16'h01FF, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'h11, 16'h01FF, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'h22, 16'h2211, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);
      add(1'b0, 1'b1, 1'b1, 8'h33, 16'h2211, 1'b0, 1'b0, 8'd1, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 8'h00, 16'h2211, 1'b0, 1'b1, 8'd1, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 8'h00, 16'h2211, 1'b0, 1'b0, 8'd1, 1'b0, 1'b0);
      // HI waits for its byte; leave the frame open after one word
      add(1'b1, 1'b0, 1'b0, 8'h00, 16'h2211, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'h44, 16'h2211, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 8'h00, 16'h2211, 1'b0, 1'b0, 8'd0, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b1, 8'h55, 16'h5544, 1'b1, 1'b0, 8'd1, 1'b1, 1'b0);

      foreach (vecs[i]) begin
         cycle(vecs[i].st, vecs[i].sp, vecs[i].bv, vecs[i].b);
         check($sformatf("vec%0d", i), pack_out(),
               {4'd0, vecs[i].e_data, vecs[i].e_go, vecs[i].e_fin, vecs[i].e_wc,
                vecs[i].e_busy, vecs[i].e_fe});
      end

      // asynchronous reset mid-frame, observed before any clock edge
      start = 1'b0; stop = 1'b0; byte_valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", pack_out(), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      check("post_reset_stop", pack_out(), 32'd0);
      cycle(1'b0, 1'b0, 1'b1, 8'h12);
      cycle(1'b0, 1'b1, 1'b1, 8'h34);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      check("post_reset_idle", pack_out(), 32'd0);

      // 300-word frame saturates the counter at 255
      cycle(1'b1, 1'b0, 1'b0, 8'h00);
      go_count = 0;
      last_word = 16'h0000;
      for (int i = 0; i < 300; i++) begin
         lo_b = i[7:0];
         hi_b = ~lo_b;
         cycle(1'b0, 1'b0, 1'b1, lo_b);
         cycle(1'b0, 1'b0, 1'b1, hi_b);
         last_word = {hi_b, lo_b};
         if (go) go_count++;
         if (i == 253) check("wc_254", {24'd0, word_count}, 32'd254);
         if (i == 254) check("wc_255", {24'd0, word_count}, 32'd255);
      end
      check("sat_wc", {24'd0, word_count}, 32'd255);
      check("sat_data", {16'd0, data_out}, {16'd0, last_word});
      check("sat_go_count", go_count, 32'd1);
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      check("sat_end", {30'd0, finish, busy}, 32'd1);
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      check("sat_finish", {23'd0, finish, word_count}, {23'd0, 1'b1, 8'd255});
      cycle(1'b0, 1'b0, 1'b0, 8'h00);
      check("sat_finish_once", {31'd0, finish}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/range_input_framer.md
RANGE_INPUT_FRAMER -- requirements
Module: range_input_framer

Interface
REQ-001 Parameter WIDTH, default 16: width of the assembled sample word; SHALL be 16 (two bytes).
REQ-002 Parameter CNT_W, default 8: width of the word counter.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; ports clock and reset.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 byte_in  input  8  incoming byte from the 8-bit pin bus.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 start  input  1  begin a new frame (level sampled each cycle).
REQ-009 stop  input  1  end the current frame.
REQ-010 data_out  output  WIDTH  most recently assembled word, held until the next word completes; drives the downstream data_in.
REQ-011 go  output  1  one-cycle strobe marking the first word of a frame; drives the downstream go.
REQ-012 finish  output  1  one-cycle strobe marking the end of a frame; drives the downstream finish.
REQ-013 word_count  output  CNT_W  number of words completed in the current frame, saturating.
REQ-014 busy  output  1  high whenever the state is not IDLE.
REQ-015 frame_error  output  1  sticky error flag for the last frame.

Function
REQ-016 The FSM SHALL have four states: IDLE, LO (awaiting low byte), HI (awaiting high byte) and END (issuing finish).
REQ-017 IDLE: start=1 SHALL transition to LO, clear word_count and clear frame_error; stop alone SHALL be ignored; start and stop together SHALL be treated as start only.
REQ-018 LO, byte_valid=1 and stop=0: the block SHALL capture byte_in into a low-byte register and transition to HI.
REQ-019 HI, byte_valid=1: the block SHALL register data_out = {byte_in, low byte}, increment word_count (saturating at 2^CNT_W-1) and transition to LO.
REQ-020 go SHALL be registered and asserted for exactly one cycle, in the same cycle the first word of a frame appears on data_out (word_count==0 before the increment); later words SHALL update data_out with go=0.
REQ-021 LO, stop=1 with word_count>0: the block SHALL transition to END, dropping any byte_valid in that cycle.
REQ-022 HI, stop=1 and byte_valid=1: the word SHALL complete as in REQ-019/020, and the block SHALL transition to END.
REQ-023 HI, stop=1 and byte_valid=0: the block SHALL discard the partial byte, set frame_error and transition to END.
REQ-024 stop=1 in LO with word_count==0: the block SHALL set frame_error and return to IDLE without asserting finish, because finish without a preceding go is a downstream error.
REQ-025 END: finish SHALL be 1 for exactly one cycle, after which the block SHALL transition to IDLE unconditionally; start during END SHALL be ignored.
REQ-026 go and finish SHALL never be high in the same cycle; finish SHALL follow the last go by at least one cycle.
REQ-027 start in LO, HI or END SHALL be ignored.
REQ-028 byte_valid in IDLE or END SHALL be ignored.
REQ-029 data_out SHALL hold its value across frames until a new word completes.
REQ-030 frame_error SHALL remain set until the next accepted start or reset.

Reset
REQ-031 Reset SHALL take effect immediately, regardless of clock: state=IDLE; data_out=0; low byte=0; go=0; finish=0; word_count=0; busy=0; frame_error=0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no finish pulse; after release the block SHALL accept only a new start.

Verification
REQ-033 Two-word frame: start, then bytes 0x34, 0x12, 0x78, 0x56, then stop -> data_out=0x1234 with go=1 for one cycle; data_out=0x5678 with go=0; finish=1 one cycle later; word_count=2; frame_error=0.
REQ-034 Odd byte count: start, bytes 0xAA, 0xBB, 0xCC, then stop while in HI -> data_out=0xBBAA, finish=1, frame_error=1, word_count=1.
REQ-035 Empty frame: start then stop with no bytes -> finish never asserted, frame_error=1, back in IDLE; the next start clears frame_error.
REQ-036 Simultaneous events: byte_valid=1 carrying the high byte 0x01 and stop=1 in the same cycle with low byte 0xFF -> data_out=0x01FF, then finish the following cycle; go and finish never overlap. start+stop together in IDLE -> block enters LO.
REQ-037 Reset mid-frame after one word -> all outputs 0 immediately, no finish; a later stop is ignored.
REQ-038 Saturation: 300 words with CNT_W=8 -> word_count holds at 255, finish is issued normally.
